flush_ctrl: RTL and testbench
=============================

FLUSH_CTRL -- requirements
Module: flush_ctrl

Interface
REQ-001 Parameter PC_W, default 32, width of all PC/entry buses.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 wb_except  in  1  WB exception commit, already qualified by WB valid.
REQ-005 wb_is_tlbr  in  1  committing exception is TLB refill; meaningful only with wb_except.
REQ-006 wb_ertn  in  1  WB ertn commit, already qualified.
REQ-007 wb_refetch  in  1  WB refetch-flush commit, already qualified.
REQ-008 wb_refetch_pc  in  PC_W  PC of refetching instruction.
REQ-009 csr_eentry, csr_tlbrentry, csr_era  in  PC_W each  CSR redirect targets.
REQ-010 if_redirect_valid  out  1  redirect request to IF.
REQ-011 if_redirect_pc  out  PC_W  redirect target.
REQ-012 if_redirect_ready  in  1  IF accepts redirect this cycle.
REQ-013 flush_pipe  out  1  kill IF/ID/EX/MEM contents.
REQ-014 wb_block  out  1  WB must not accept new instructions.
REQ-015 cnt_except, cnt_ertn, cnt_refetch  out  16 each  event statistics.

Function
REQ-016 Two-state FSM: IDLE, REDIR; state, target and outputs are registered.
REQ-017 Events are sampled in IDLE, and in REDIR during the cycle where if_redirect_valid & if_redirect_ready.
REQ-018 Priority when several events are sampled together: wb_except > wb_ertn > wb_refetch; lower ones dropped, not counted.
REQ-019 Target: except & wb_is_tlbr -> csr_tlbrentry; except & ~wb_is_tlbr -> csr_eentry; ertn -> csr_era; refetch -> wb_refetch_pc; captured at sampling edge.
REQ-020 Event sampled at edge N -> state REDIR, if_redirect_valid=1, flush_pipe=1 from cycle N+1 (latency 1).
REQ-021 In REDIR if_redirect_valid and if_redirect_pc stay stable until handshake completes.
REQ-022 flush_pipe and wb_block equal 1 for every cycle in REDIR, 0 in IDLE.
REQ-023 Handshake completes in a cycle with valid & ready; next state IDLE unless a new event is sampled that cycle, in which case stay REDIR with the new target loaded.
REQ-024 Events arriving in REDIR outside the handshake cycle are ignored and not counted.
REQ-025 if_redirect_ready while in IDLE has no effect.
REQ-026 Minimum REDIR duration is one cycle (ready already high).
REQ-027 Counters increment by 1 per accepted event of their type, saturate at 16'hFFFF.

Reset
REQ-028 resetn low asynchronously forces IDLE, if_redirect_valid=0, if_redirect_pc=0, flush_pipe=0, wb_block=0, all counters 0.
REQ-029 Reset mid-REDIR aborts the pending redirect; no request survives reset.
REQ-030 First event sampling occurs at the first posedge after resetn deasserts.

Configuration
REQ-031 Macro FLUSH_STAT_EN: defined -> REQ-027 counters implemented.
REQ-032 FLUSH_STAT_EN undefined -> no counter flops, cnt_* tied to 0; all other behaviour identical.

Verification
REQ-033 Exception: wb_except=1, wb_is_tlbr=0, csr_eentry=0x1C008000, ready=1 -> next cycle valid=1, pc=0x1C008000, flush_pipe=1 one cycle, then IDLE.
REQ-034 Backpressure: ertn with csr_era=0x1C000104, ready low 3 cycles -> valid, flush_pipe, wb_block high 4 cycles, pc stable 0x1C000104.
REQ-035 Simultaneous: except(tlbr, tlbrentry=0x1C00F000)+ertn+refetch same cycle -> pc=0x1C00F000, cnt_except=1, cnt_ertn=0, cnt_refetch=0.
REQ-036 Back-to-back: refetch pc=0x1C000200 sampled in handshake cycle of prior redirect -> REDIR continues, pc becomes 0x1C000200 with no IDLE cycle.
REQ-037 Reset: resetn low while REDIR with ready=0 -> all outputs 0 immediately, IDLE after release.
REQ-038 Saturation (FLUSH_STAT_EN): 65537 refetch events -> cnt_refetch=0xFFFF; without macro cnt_refetch=0.

Source files
------------

// File: rtl/flush_ctrl.sv
// flush_ctrl: turns committed WB exceptions, ertn and refetch flushes into a
// single registered redirect request for IF, and holds the rest of the
// pipeline flushed while that request is outstanding.
// Optional macro FLUSH_STAT_EN enables the saturating 16-bit event counters;
// without it, cnt_* are tied to zero and no counter flops exist.
module flush_ctrl #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_except,
    input  logic            wb_is_tlbr,
    input  logic            wb_ertn,
    input  logic            wb_refetch,
    input  logic [PC_W-1:0] wb_refetch_pc,
    input  logic [PC_W-1:0] csr_eentry,
    input  logic [PC_W-1:0] csr_tlbrentry,
    input  logic [PC_W-1:0] csr_era,
    output logic            if_redirect_valid,
    output logic [PC_W-1:0] if_redirect_pc,
    input  logic            if_redirect_ready,
    output logic            flush_pipe,
    output logic            wb_block,
    output logic [15:0]     cnt_except,
    output logic [15:0]     cnt_ertn,
    output logic [15:0]     cnt_refetch
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            sample;
    logic            take_except, take_ertn, take_refetch;

    // Event acceptance: sampled in IDLE, or in the REDIR handshake cycle; fixed priority
    always_comb begin
        sample       = (state_q == IDLE) || (if_redirect_valid && if_redirect_ready);
        take_except  = sample && wb_except;
        take_ertn    = sample && !wb_except && wb_ertn;
        take_refetch = sample && !wb_except && !wb_ertn && wb_refetch;
    end

    // Next state and redirect target; a new event in the handshake cycle keeps REDIR
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (take_except) begin
            state_d = REDIR;
            pc_d    = wb_is_tlbr ? csr_tlbrentry : csr_eentry;
        end else if (take_ertn) begin
            state_d = REDIR;
            pc_d    = csr_era;
        end else if (take_refetch) begin
            state_d = REDIR;
            pc_d    = wb_refetch_pc;
        end else if (state_q == REDIR && if_redirect_ready) begin
            state_d = IDLE;
        end
    end

    // State and target registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign if_redirect_valid = (state_q == REDIR);
    assign if_redirect_pc    = pc_q;
    assign flush_pipe        = (state_q == REDIR);
    assign wb_block          = (state_q == REDIR);

`ifdef FLUSH_STAT_EN
    logic [15:0] cnt_except_q, cnt_except_d;
    logic [15:0] cnt_ertn_q, cnt_ertn_d;
    logic [15:0] cnt_refetch_q, cnt_refetch_d;

    // Saturating per-type counters of accepted events
    always_comb begin
        cnt_except_d  = cnt_except_q;
        cnt_ertn_d    = cnt_ertn_q;
        cnt_refetch_d = cnt_refetch_q;
        if (take_except && cnt_except_q != '1) begin
            cnt_except_d = cnt_except_q + 16'd1;
        end
        if (take_ertn && cnt_ertn_q != '1) begin
            cnt_ertn_d = cnt_ertn_q + 16'd1;
        end
        if (take_refetch && cnt_refetch_q != '1) begin
            cnt_refetch_d = cnt_refetch_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_except_q  <= '0;
            cnt_ertn_q    <= '0;
            cnt_refetch_q <= '0;
        end else begin
            cnt_except_q  <= cnt_except_d;
            cnt_ertn_q    <= cnt_ertn_d;
            cnt_refetch_q <= cnt_refetch_d;
        end
    end

    assign cnt_except  = cnt_except_q;
    assign cnt_ertn    = cnt_ertn_q;
    assign cnt_refetch = cnt_refetch_q;
`else
    assign cnt_except  = '0;
    assign cnt_ertn    = '0;
    assign cnt_refetch = '0;
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// Self-checking bench for flush_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_flush_ctrl;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic            wb_except, wb_is_tlbr, wb_ertn, wb_refetch;
    logic [PC_W-1:0] wb_refetch_pc, csr_eentry, csr_tlbrentry, csr_era;
    logic            if_redirect_valid;
    logic [PC_W-1:0] if_redirect_pc;
    logic            if_redirect_ready;
    logic            flush_pipe, wb_block;
    logic [15:0]     cnt_except, cnt_ertn, cnt_refetch;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending redirect flag, its target, event totals
    bit              m_pend;
    logic [PC_W-1:0] m_pc;
    int              m_ce, m_cr, m_cf;

    always #5 clk = ~clk;

    flush_ctrl #(.PC_W(PC_W)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .wb_except         (wb_except),
        .wb_is_tlbr        (wb_is_tlbr),
        .wb_ertn           (wb_ertn),
        .wb_refetch        (wb_refetch),
        .wb_refetch_pc     (wb_refetch_pc),
        .csr_eentry        (csr_eentry),
        .csr_tlbrentry     (csr_tlbrentry),
        .csr_era           (csr_era),
        .if_redirect_valid (if_redirect_valid),
        .if_redirect_pc    (if_redirect_pc),
        .if_redirect_ready (if_redirect_ready),
        .flush_pipe        (flush_pipe),
        .wb_block          (wb_block),
        .cnt_except        (cnt_except),
        .cnt_ertn          (cnt_ertn),
        .cnt_refetch       (cnt_refetch)
    );

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef FLUSH_STAT_EN
        logic [15:0] v;
        v = (c > 65535) ? 16'hFFFF : 16'(c);
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_pc   = '0;
        m_ce   = 0;
        m_cr   = 0;
        m_cf   = 0;
    endtask

    // One clock: the model consumes the inputs present at the edge, then we step off the edge
    task automatic tick();
        bit accept;
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            accept = !m_pend || if_redirect_ready;
            if (accept && wb_except) begin
                m_pend = 1'b1;
                m_pc   = wb_is_tlbr ? csr_tlbrentry : csr_eentry;
                m_ce++;
            end else if (accept && wb_ertn) begin
                m_pend = 1'b1;
                m_pc   = csr_era;
                m_cr++;
            end else if (accept && wb_refetch) begin
                m_pend = 1'b1;
                m_pc   = wb_refetch_pc;
                m_cf++;
            end else if (accept) begin
                m_pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic clear_events();
        wb_except  = 1'b0;
        wb_is_tlbr = 1'b0;
        wb_ertn    = 1'b0;
        wb_refetch = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_events();
        if_redirect_ready = 1'b0;
        model_reset();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_events();
        if_redirect_ready = 1'b1;
        wb_refetch_pc = '0; csr_eentry = '0; csr_tlbrentry = '0; csr_era = '0;
        model_reset();
        #2;
        n_cmp++;
        if ({if_redirect_valid, flush_pipe, wb_block} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 000", {if_redirect_valid, flush_pipe, wb_block});
        end
        n_cmp++;
        if (if_redirect_pc !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc: got %h want 0", if_redirect_pc);
        end
        n_cmp++;
        if ({cnt_except, cnt_ertn, cnt_refetch} !== 48'h0) begin
            n_bad++; $display("FAIL reset_cnt: got %h want 0", {cnt_except, cnt_ertn, cnt_refetch});
        end
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_exception();
        csr_eentry = 32'h1C008000;
        if_redirect_ready = 1'b1;
        wb_except = 1'b1;
        tick();
        clear_events();
        n_cmp++;
        if ({if_redirect_valid, flush_pipe, wb_block} !== 3'b111) begin
            n_bad++; $display("FAIL exc_ctl: got %b want 111", {if_redirect_valid, flush_pipe, wb_block});
        end
        n_cmp++;
        if (if_redirect_pc !== 32'h1C008000) begin
            n_bad++; $display("FAIL exc_pc: got %h want 1c008000", if_redirect_pc);
        end
        n_cmp++;
        if (cnt_except !== exp_cnt(1)) begin
            n_bad++; $display("FAIL exc_cnt: got %h want %h", cnt_except, exp_cnt(1));
        end
        tick();
        n_cmp++;
        if ({if_redirect_valid, flush_pipe, wb_block} !== 3'b000) begin
            n_bad++; $display("FAIL exc_idle: got %b want 000", {if_redirect_valid, flush_pipe, wb_block});
        end
    endtask

    task automatic test_backpressure();
        csr_era = 32'h1C000104;
        if_redirect_ready = 1'b0;
        wb_ertn = 1'b1;
        tick();
        clear_events();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                wb_refetch = 1'b1;            // arrives outside handshake: must be ignored
                wb_refetch_pc = 32'hDEAD0000;
            end else begin
                wb_refetch = 1'b0;
            end
            if (i == 3) if_redirect_ready = 1'b1;
            n_cmp++;
            if ({if_redirect_valid, flush_pipe, wb_block} !== 3'b111) begin
                n_bad++; $display("FAIL bp_ctl[%0d]: got %b want 111", i, {if_redirect_valid, flush_pipe, wb_block});
            end
            n_cmp++;
            if (if_redirect_pc !== 32'h1C000104) begin
                n_bad++; $display("FAIL bp_pc[%0d]: got %h want 1c000104", i, if_redirect_pc);
            end
            tick();
        end
        n_cmp++;
        if (if_redirect_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_idle: got %b want 0", if_redirect_valid);
        end
        n_cmp++;
        if (cnt_refetch !== exp_cnt(0) || cnt_ertn !== exp_cnt(1)) begin
            n_bad++; $display("FAIL bp_cnt: got ertn=%h refetch=%h want %h %h", cnt_ertn, cnt_refetch, exp_cnt(1), exp_cnt(0));
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        csr_tlbrentry = 32'h1C00F000;
        csr_eentry = 32'h1C008000;
        csr_era = 32'h1C000104;
        wb_refetch_pc = 32'h1C000300;
        if_redirect_ready = 1'b1;
        wb_except = 1'b1; wb_is_tlbr = 1'b1; wb_ertn = 1'b1; wb_refetch = 1'b1;
        tick();
        clear_events();
        n_cmp++;
        if (if_redirect_pc !== 32'h1C00F000 || if_redirect_valid !== 1'b1) begin
            n_bad++; $display("FAIL sim_pc: got %h/%b want 1c00f000/1", if_redirect_pc, if_redirect_valid);
        end
        n_cmp++;
        if ({cnt_except, cnt_ertn, cnt_refetch} !== {exp_cnt(1), exp_cnt(0), exp_cnt(0)}) begin
            n_bad++; $display("FAIL sim_cnt: got %h %h %h want %h 0 0", cnt_except, cnt_ertn, cnt_refetch, exp_cnt(1));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        csr_eentry = 32'h1C008000;
        if_redirect_ready = 1'b0;
        wb_except = 1'b1;
        tick();
        clear_events();
        tick();
        if_redirect_ready = 1'b1;
        wb_refetch = 1'b1;
        wb_refetch_pc = 32'h1C000200;
        tick();
        clear_events();
        n_cmp++;
        if (if_redirect_valid !== 1'b1 || if_redirect_pc !== 32'h1C000200) begin
            n_bad++; $display("FAIL b2b_pc: got %b/%h want 1/1c000200", if_redirect_valid, if_redirect_pc);
        end
        tick();
        n_cmp++;
        if (if_redirect_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: got %b want 0", if_redirect_valid);
        end
    endtask

    task automatic test_reset_mid_redirect();
        if_redirect_ready = 1'b0;
        wb_ertn = 1'b1;
        tick();
        clear_events();
        n_cmp++;
        if (if_redirect_valid !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre: got %b want 1", if_redirect_valid);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({if_redirect_valid, flush_pipe, wb_block, if_redirect_pc} !== {3'b000, 32'h0}) begin
            n_bad++; $display("FAIL rst_async: got %b %h want 000 0", {if_redirect_valid, flush_pipe, wb_block}, if_redirect_pc);
        end
        n_cmp++;
        if ({cnt_except, cnt_ertn, cnt_refetch} !== 48'h0) begin
            n_bad++; $display("FAIL rst_cnt: got %h want 0", {cnt_except, cnt_ertn, cnt_refetch});
        end
        tick();
        resetn = 1'b1;
        tick();
        n_cmp++;
        if (if_redirect_valid !== 1'b0 || flush_pipe !== 1'b0) begin
            n_bad++; $display("FAIL rst_release: got %b%b want 00", if_redirect_valid, flush_pipe);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            wb_except         = ($urandom_range(0, 7) == 0);
            wb_is_tlbr        = $urandom_range(0, 1) == 1;
            wb_ertn           = ($urandom_range(0, 5) == 0);
            wb_refetch        = ($urandom_range(0, 3) == 0);
            wb_refetch_pc     = $urandom;
            csr_eentry        = $urandom;
            csr_tlbrentry     = $urandom;
            csr_era           = $urandom;
            if_redirect_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++;
            if (if_redirect_valid !== m_pend || flush_pipe !== m_pend || wb_block !== m_pend) begin
                n_bad++; $display("FAIL rnd_ctl[%0d]: got %b%b%b want %b", i, if_redirect_valid, flush_pipe, wb_block, m_pend);
            end
            if (m_pend) begin
                n_cmp++;
                if (if_redirect_pc !== m_pc) begin
                    n_bad++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, if_redirect_pc, m_pc);
                end
            end
            n_cmp++;
            if ({cnt_except, cnt_ertn, cnt_refetch} !== {exp_cnt(m_ce), exp_cnt(m_cr), exp_cnt(m_cf)}) begin
                n_bad++; $display("FAIL rnd_cnt[%0d]: got %h %h %h want %h %h %h", i,
                    cnt_except, cnt_ertn, cnt_refetch, exp_cnt(m_ce), exp_cnt(m_cr), exp_cnt(m_cf));
            end
        end
        clear_events();
        if_redirect_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_saturation();
        logic [15:0] want;
        do_reset();
        if_redirect_ready = 1'b1;
        wb_refetch = 1'b1;
        wb_refetch_pc = 32'h1C000400;
        repeat (65537) tick();
        clear_events();
`ifdef FLUSH_STAT_EN
        want = 16'hFFFF;
`else
        want = 16'h0000;
`endif
        n_cmp++;
        if (cnt_refetch !== want) begin
            n_bad++; $display("FAIL sat_refetch: got %h want %h", cnt_refetch, want);
        end
        n_cmp++;
        if (cnt_except !== 16'h0 || cnt_ertn !== 16'h0) begin
            n_bad++; $display("FAIL sat_others: got %h %h want 0 0", cnt_except, cnt_ertn);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_backpressure();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_redirect();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
